// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks EX/MEM destination shadows and steers bubbles, stalls and flushes.
// Optional build macro: HAZARD_FORWARD_EN (forwarding present, load-use stalls only).
module hazard_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_uses_rt,
  input  logic       id_regdst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_jump,
  input  logic       ex_branch_taken,
  output logic       controlmux,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush
);

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
  } slot_t;

  slot_t      ex_s_q, ex_s_d;
  slot_t      mem_s_q, mem_s_d;
  logic       ex_match;
  logic       mem_match;
  logic       data_stall;
  logic       issue;
  logic [4:0] id_dst;

  always_comb begin
    ex_match  = ex_s_q.v  && ((ex_s_q.dst  == id_rs) || (id_uses_rt && (ex_s_q.dst  == id_rt)));
    mem_match = mem_s_q.v && ((mem_s_q.dst == id_rs) || (id_uses_rt && (mem_s_q.dst == id_rt)));
`ifdef HAZARD_FORWARD_EN
    data_stall = ex_match && ex_s_q.ld;
`else
    data_stall = ex_match || mem_match;
`endif
  end

  // Outputs are held low while reset is asserted, independent of the clock.
  always_comb begin
    controlmux  = 1'b1;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (!rst_n) begin
      controlmux  = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_branch_taken) begin
      controlmux  = 1'b0;
      if_id_flush = 1'b1;
    end else if (data_stall && id_valid) begin
      controlmux  = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (id_jump && id_valid) begin
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    id_dst  = id_regdst ? id_rd : id_rt;
    issue   = id_valid && controlmux;
    ex_s_d  = '0;
    if (issue) begin
      ex_s_d.v   = id_regwrite && (id_dst != 5'd0);
      ex_s_d.dst = id_dst;
      ex_s_d.ld  = id_memread;
    end
    mem_s_d = ex_s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s_q  <= '0;
      mem_s_q <= '0;
    end else begin
      ex_s_q  <= ex_s_d;
      mem_s_q <= mem_s_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expected outputs are hand-derived for the active build.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_rd;
  logic       id_uses_rt;
  logic       id_regdst;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_jump;
  logic       ex_branch_taken;
  logic       controlmux;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;

  int checks;
  int errors;

  // Output vector order: {controlmux, pc_write, if_id_write, if_id_flush}
  localparam logic [3:0] RUN   = 4'b1110;
  localparam logic [3:0] STALL = 4'b0000;
  localparam logic [3:0] JUMP  = 4'b1111;
  localparam logic [3:0] BRAN  = 4'b0111;
  localparam logic [3:0] RST   = 4'b0000;

  hazard_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_uses_rt      (id_uses_rt),
    .id_regdst       (id_regdst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .controlmux      (controlmux),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {controlmux, pc_write, if_id_write, if_id_flush};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic uses_rt, input logic regdst, input logic regwrite,
                       input logic memread, input logic jump);
    id_valid        = 1'b1;
    id_rs           = rs;
    id_rt           = rt;
    id_rd           = rd;
    id_uses_rt      = uses_rt;
    id_regdst       = regdst;
    id_regwrite     = regwrite;
    id_memread      = memread;
    id_jump         = jump;
    ex_branch_taken = 1'b0;
  endtask

  // Check mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] exp);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain;
    nop(); cyc("drain0", RUN);
    nop(); cyc("drain1", RUN);
  endtask

  task automatic add3;   // add $3,$1,$2
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sub4;   // sub $4,$3,$5
    instr(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw8;    // lw $8,0($1)
    instr(5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add9;   // add $9,$8,$1
    instr(5'd8, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic indep;  // add $12,$10,$11
    instr(5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    rst_n = 1'b0;
    instr(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk("reset_hold", RST);
    repeat (2) @(posedge clk);
    ex_branch_taken = 1'b1;
    #1;
    chk("reset_hold_branch", RST);
    @(negedge clk);
    nop();
    rst_n = 1'b1;
    #1;
    chk("reset_release", RUN);
    @(posedge clk);
    #1;

    // RAW on the EX producer
    add3(); cyc("ex_dep_prod", RUN);
    sub4(); cyc("ex_dep_c0", FWD ? RUN : STALL);
    sub4(); cyc("ex_dep_c1", FWD ? RUN : STALL);
    sub4(); cyc("ex_dep_c2", RUN);
    drain();

    // one independent instruction in between
    add3();  cyc("mem_dep_prod", RUN);
    indep(); cyc("mem_dep_gap", RUN);
    sub4();  cyc("mem_dep_c0", FWD ? RUN : STALL);
    sub4();  cyc("mem_dep_c1", RUN);
    drain();

    // two in between: WB producer never stalls
    add3();  cyc("wb_dep_prod", RUN);
    indep(); cyc("wb_dep_gap0", RUN);
    indep(); cyc("wb_dep_gap1", RUN);
    sub4();  cyc("wb_dep_c0", RUN);
    drain();

    // load-use
    lw8();  cyc("lu_load", RUN);
    add9(); cyc("lu_c0", STALL);
    add9(); cyc("lu_c1", FWD ? RUN : STALL);
    add9(); cyc("lu_c2", RUN);
    drain();

    // $0 destination never matches
    instr(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); cyc("zero_load", RUN);
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cyc("zero_use", RUN);
    drain();

    // jump without hazard, then jump overridden by a branch
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc("jump_plain", JUMP);
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_branch_taken = 1'b1;
    cyc("jump_vs_branch", BRAN);
    drain();

    // jump behind a load-use hazard
    lw8(); cyc("jlu_load", RUN);
    instr(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc("jlu_c0", STALL);
    instr(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc("jlu_c1", FWD ? JUMP : STALL);
    instr(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc("jlu_c2", JUMP);
    drain();

    // branch beats load-use; discarded add must not enter EX
    lw8();  cyc("br_load", RUN);
    add9();
    ex_branch_taken = 1'b1;
    cyc("br_over_stall", BRAN);
    instr(5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc("br_after", RUN);
    drain();

    // invalid ID slot: no stall and EX fills with an empty slot
    lw8(); cyc("inv_load", RUN);
    add9();
    id_valid = 1'b0;
    cyc("inv_id", RUN);
    add9(); cyc("inv_after", FWD ? RUN : STALL);
    drain();

    // rt compared only when the instruction reads it
    add3(); cyc("rt_prod", RUN);
    instr(5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc("rt_unused", RUN);
    instr(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc("rt_used", FWD ? RUN : STALL);
    drain();

    // reset in the middle of a stall clears everything
    lw8();  cyc("mrst_load", RUN);
    add9();
    @(negedge clk);
    chk("mrst_stall", STALL);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_async", RST);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("mrst_after", RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
